// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver, LSB first, sampling at the centre of each bit.
//
// The line is brought into the clk domain through a two-flop synchroniser.
// A falling edge on the synchronised line starts a frame. The start bit is
// re-checked half a bit later, so short low glitches are rejected without
// any output. From that point every sample is taken one full bit period
// after the previous one, which keeps all data and stop samples near the
// middle of their bits.
//
// Handshake: there is no valid/ready pair. rx_done is a one-cycle strobe
// that qualifies data_rx, and there is no backpressure. The consumer must
// capture data_rx before the next rx_done. frame_err is a one-cycle strobe
// for a frame whose stop bit was low. The two strobes are never high in the
// same cycle.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD_RATE  line rate in bit/s (CLK_FREQ / BAUD_RATE must be >= 4)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx_in      serial line, idle high, asynchronous to clk
//   data_rx    last correctly framed byte, held until the next good frame
//   rx_done    one-cycle pulse in the cycle data_rx is updated
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   rx_busy    high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] data_rx,
   output logic       rx_done,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [2:0]      idx, idx_n;
   logic [7:0]      shreg, shreg_n;
   logic [7:0]      data_n;
   logic            done_n, ferr_n;

   // Synchroniser and edge-detect history. These reset to 1 (idle line) so
   // that leaving reset with a high line never looks like a start edge.
   logic            sync1, rx_s, rx_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1   <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= rx_in;
         rx_s    <= sync1;
         rx_prev <= rx_s;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         data_rx   <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         shreg     <= shreg_n;
         data_rx   <= data_n;
         rx_done   <= done_n;
         frame_err <= ferr_n;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shreg_n = shreg;
      data_n  = data_rx;
      done_n  = 1'b0;
      ferr_n  = 1'b0;

      case (state)
         IDLE: begin
            // Only a 1->0 transition starts a frame; a line that simply
            // stays low does not retrigger.
            if (rx_prev && !rx_s) begin
               state_n = START;
               cnt_n   = '0;
            end
         end

         START: begin
            if (cnt == CW'(HALF_BIT - 1)) begin
               cnt_n = '0;
               if (!rx_s) begin
                  state_n = DATA;
                  idx_n   = '0;
               end else begin
                  // Line went back high before mid start bit: glitch.
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         DATA: begin
            if (cnt == CW'(CLKS_PER_BIT - 1)) begin
               cnt_n        = '0;
               shreg_n[idx] = rx_s;
               if (idx == 3'd7) begin
                  state_n = STOP;
               end else begin
                  idx_n = idx + 3'd1;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         STOP: begin
            if (cnt == CW'(CLKS_PER_BIT - 1)) begin
               cnt_n   = '0;
               state_n = IDLE;
               if (rx_s) begin
                  data_n = shreg;
                  done_n = 1'b1;
               end else begin
                  ferr_n = 1'b1;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Derived from the state register, so it drops in the same cycle the
   // rx_done / frame_err strobe is registered.
   assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx : directed bench for uart_rx at 16 clocks per bit.
// A table of frames with hand-computed outcomes is driven onto rx_in, then
// hand-written sequences cover glitch rejection, reset mid-frame and
// back-to-back frames. A negedge monitor records every rx_done pulse.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk;
   logic       rst;
   logic       rx_in;
   logic [7:0] data_rx;
   logic       rx_done;
   logic       frame_err;
   logic       rx_busy;

   uart_rx #(.CLK_FREQ(160), .BAUD_RATE(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_in     (rx_in),
      .data_rx   (data_rx),
      .rx_done   (rx_done),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- counters ----------------
   int vectors     = 0;
   int miscompares = 0;

   // ---------------- monitor / scoreboard ----------------
   logic [7:0] got_q[$];
   int         done_cnt   = 0;
   int         ferr_cnt   = 0;
   int         last_done  = 0;
   int         prev_done  = 0;
   logic       busy_seen  = 1'b0;
   logic [7:0] prev_data  = 8'h00;

   always @(negedge clk) begin
      if (rx_busy) busy_seen = 1'b1;
      if (rx_done) begin
         got_q.push_back(data_rx);
         done_cnt++;
         prev_done = last_done;
         last_done = cyc;
         if (rx_busy) begin
            miscompares++;
            $display("FAIL busy_at_done: rx_busy=%0b required 0 (cycle %0d)", rx_busy, cyc);
         end
      end
      if (frame_err) ferr_cnt++;
      if (rx_done && frame_err) begin
         miscompares++;
         $display("FAIL strobes_exclusive: rx_done=1 frame_err=1 required not both (cycle %0d)", cyc);
      end
      if (rst && !rx_done && data_rx !== prev_data) begin
         miscompares++;
         $display("FAIL data_stable: data_rx %h -> %h without rx_done (cycle %0d)", prev_data, data_rx, cyc);
      end
      prev_data = data_rx;
   end

   // ---------------- driver tasks ----------------
   // All tasks are entered and left 1 time unit after a rising edge.
   task automatic drive_bit(input logic b);
      rx_in = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop);
      rx_in = 1'b1;
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic check_range(input string name, input int got, input int lo, input int hi);
      vectors++;
      if (got < lo || got > hi) begin
         miscompares++;
         $display("FAIL %s: got %0d required %0d..%0d", name, got, lo, hi);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_done;
      logic       exp_ferr;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int d0, f0, start_cyc, b2b_start;

      vecs[0] = '{8'h11, 1'b1, 1'b1, 1'b0, 8'h11};
      vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h11};  // bad stop, data held
      vecs[2] = '{8'h7E, 1'b1, 1'b1, 1'b0, 8'h7E};
      vecs[3] = '{8'hA3, 1'b1, 1'b1, 1'b0, 8'hA3};
      vecs[4] = '{8'h55, 1'b1, 1'b1, 1'b0, 8'h55};
      vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h80};
      vecs[6] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01};
      vecs[7] = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'h01};  // bad stop, data held
      vecs[8] = '{8'h96, 1'b1, 1'b1, 1'b0, 8'h96};

      rst   = 1'b0;
      rx_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_data",  {24'h0, data_rx}, 32'h00);
      check("reset_done",  {31'h0, rx_done}, 32'h0);
      check("reset_ferr",  {31'h0, frame_err}, 32'h0);
      check("reset_busy",  {31'h0, rx_busy}, 32'h0);
      rst = 1'b1;
      idle(10);

      // ---- table-driven frames ----
      for (int v = 0; v < 9; v++) begin
         d0        = done_cnt;
         f0        = ferr_cnt;
         start_cyc = cyc;
         send_frame(vecs[v].data, vecs[v].stop);
         idle(24);
         check($sformatf("v%0d_done", v), done_cnt - d0, {31'h0, vecs[v].exp_done});
         check($sformatf("v%0d_ferr", v), ferr_cnt - f0, {31'h0, vecs[v].exp_ferr});
         check($sformatf("v%0d_data", v), {24'h0, data_rx}, {24'h0, vecs[v].exp_data});
         check($sformatf("v%0d_busy", v), {31'h0, rx_busy}, 32'h0);
         if (vecs[v].exp_done && done_cnt > d0)
            check_range($sformatf("v%0d_latency", v), last_done - start_cyc, 153, 157);
      end

      // ---- glitch: 4 cycles low ----
      d0 = done_cnt;
      f0 = ferr_cnt;
      busy_seen = 1'b0;
      rx_in = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      idle(40);
      check("glitch_busy_seen", {31'h0, busy_seen}, 32'h1);
      check("glitch_done", done_cnt - d0, 32'h0);
      check("glitch_ferr", ferr_cnt - f0, 32'h0);
      check("glitch_idle", {31'h0, rx_busy}, 32'h0);
      check("glitch_data", {24'h0, data_rx}, 32'h96);

      // ---- reset during data bit 4 of 8'hC6 ----
      d0 = done_cnt;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(logic'((8'hC6 >> i) & 8'h01));
      rx_in = 1'b0;                 // bit 4 of C6
      repeat (CPB / 2) @(posedge clk);
      #1;
      check("midframe_busy_before", {31'h0, rx_busy}, 32'h1);
      rst = 1'b0;
      #1;
      check("rst_data", {24'h0, data_rx}, 32'h00);
      check("rst_busy", {31'h0, rx_busy}, 32'h0);
      check("rst_done", {31'h0, rx_done}, 32'h0);
      check("rst_ferr", {31'h0, frame_err}, 32'h0);
      rx_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      idle(20);
      check("rst_no_pulse", done_cnt - d0, 32'h0);
      send_frame(8'hC6, 1'b1);
      idle(24);
      check("after_rst_done", done_cnt - d0, 32'h1);
      check("after_rst_data", {24'h0, data_rx}, 32'hC6);

      // ---- back-to-back 8'h00 then 8'hFF ----
      d0 = done_cnt;
      got_q.delete();
      b2b_start = cyc;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(24);
      check("b2b_count", done_cnt - d0, 32'h2);
      if (got_q.size() == 2) begin
         check("b2b_first",  {24'h0, got_q[0]}, 32'h00);
         check("b2b_second", {24'h0, got_q[1]}, 32'hFF);
         check("b2b_spacing", last_done - prev_done, 32'd160);
         check_range("b2b_latency", prev_done - b2b_start, 153, 157);
      end
      check("b2b_data", {24'h0, data_rx}, 32'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
